// File: rtl/core_in_desc_queue.sv
// -----------------------------------------------------------------------------
// core_in_desc_queue
//
// Ring-buffer descriptor queue in front of a RISC-V packet core. The scheduler
// pushes descriptors over a valid/ready handshake. The core sees the oldest
// stored descriptor on in_desc/in_desc_valid and acknowledges it with
// in_desc_taken. A flush input discards everything for core re-initialisation.
//
// Ports:
//   clk, core_reset      clock, asynchronous active-high reset
//   s_desc[_valid/ready] scheduler push handshake
//   in_desc[_valid]      head descriptor to the core (zero when empty)
//   in_desc_taken        core consumed the head
//   flush                drop all stored descriptors (statistics kept)
//   occupancy            number of stored descriptors (0..DEPTH)
//   accepted_count       pushes since reset
//   stall_count          cycles with s_desc_valid && !s_desc_ready
//
// Build option: define IN_DESC_QUEUE_STATS_EN to build the statistics
// counters. Without it, accepted_count and stall_count are tied to zero.
// -----------------------------------------------------------------------------
module core_in_desc_queue #(
  parameter int DEPTH      = 16,
  parameter int DESC_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  core_reset,
  input  logic [DESC_WIDTH-1:0] s_desc,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  output logic [DESC_WIDTH-1:0] in_desc,
  output logic                  in_desc_valid,
  input  logic                  in_desc_taken,
  input  logic                  flush,
  output logic [PTR_WIDTH:0]    occupancy,
  output logic [CNT_WIDTH-1:0]  accepted_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [DESC_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH:0]    count;
  logic                  push;
  logic                  pop;

  // Ready looks only at registered state, flush and reset, so the core's
  // taken signal never reaches the scheduler combinationally. A pop on a full
  // queue therefore frees the slot for the following cycle, not this one.
  assign s_desc_ready  = (count != FULL_COUNT) && !flush && !core_reset;
  assign in_desc_valid = (count != '0);
  assign in_desc       = in_desc_valid ? mem[rd_ptr] : '0;
  assign occupancy     = count;

  assign push = s_desc_valid && s_desc_ready;
  // A pop coinciding with flush is meaningless: the queue empties anyway.
  assign pop  = in_desc_valid && in_desc_taken && !flush;

  // NOTE: the storage array has no reset; only pointers and count are
  // cleared. Stale contents are never visible because in_desc is masked to
  // zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_desc;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples the pre-edge values of push, pop and count.
  always_ff @(posedge clk or posedge core_reset) begin
    if (core_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_WIDTH + 1)'(1);
        2'b01:   count <= count - (PTR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IN_DESC_QUEUE_STATS_EN
  logic [CNT_WIDTH-1:0] accepted_q;
  logic [CNT_WIDTH-1:0] stall_q;

  // Counters are unaffected by flush and wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge core_reset) begin
    if (core_reset) begin
      accepted_q <= '0;
      stall_q    <= '0;
    end else begin
      if (push) begin
        accepted_q <= accepted_q + CNT_WIDTH'(1);
      end
      if (s_desc_valid && !s_desc_ready) begin
        stall_q <= stall_q + CNT_WIDTH'(1);
      end
    end
  end

  assign accepted_count = accepted_q;
  assign stall_count    = stall_q;
`else
  assign accepted_count = '0;
  assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_core_in_desc_queue.sv
// -----------------------------------------------------------------------------
// tb_core_in_desc_queue
//
// Self-checking bench for core_in_desc_queue. A queue-based reference model
// tracks stored descriptors and statistics; every cycle the DUT outputs are
// compared against it. Directed scenarios cover ordering, full/back-pressure,
// pointer wrap, flush, asynchronous reset and empty-pop, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_core_in_desc_queue;

  localparam int DEPTH      = 16;
  localparam int DESC_WIDTH = 64;
  localparam int CNT_WIDTH  = 32;
  localparam int PTR_WIDTH  = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic                  core_reset;
  logic [DESC_WIDTH-1:0] s_desc;
  logic                  s_desc_valid;
  logic                  s_desc_ready;
  logic [DESC_WIDTH-1:0] in_desc;
  logic                  in_desc_valid;
  logic                  in_desc_taken;
  logic                  flush;
  logic [PTR_WIDTH:0]    occupancy;
  logic [CNT_WIDTH-1:0]  accepted_count;
  logic [CNT_WIDTH-1:0]  stall_count;

  core_in_desc_queue #(
    .DEPTH     (DEPTH),
    .DESC_WIDTH(DESC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk           (clk),
    .core_reset    (core_reset),
    .s_desc        (s_desc),
    .s_desc_valid  (s_desc_valid),
    .s_desc_ready  (s_desc_ready),
    .in_desc       (in_desc),
    .in_desc_valid (in_desc_valid),
    .in_desc_taken (in_desc_taken),
    .flush         (flush),
    .occupancy     (occupancy),
    .accepted_count(accepted_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: stored descriptors in arrival order plus statistics.
  logic [DESC_WIDTH-1:0] model_q[$];
  logic [CNT_WIDTH-1:0]  model_acc;
  logic [CNT_WIDTH-1:0]  model_stall;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = (model_q.size() != DEPTH) && !flush && !core_reset;
    check("s_desc_ready", 64'(s_desc_ready), 64'(exp_ready));
    check("in_desc_valid", 64'(in_desc_valid), 64'(model_q.size() != 0));
    check("in_desc", in_desc, (model_q.size() != 0) ? model_q[0] : 64'h0);
    check("occupancy", 64'(occupancy), 64'(model_q.size()));
`ifdef IN_DESC_QUEUE_STATS_EN
    check("accepted_count", 64'(accepted_count), 64'(model_acc));
    check("stall_count", 64'(stall_count), 64'(model_stall));
`else
    check("accepted_count", 64'(accepted_count), 64'h0);
    check("stall_count", 64'(stall_count), 64'h0);
`endif
  endtask

  // Apply the queue's rules at a rising edge (reset deasserted).
  task automatic model_edge(input logic v, input logic [63:0] d,
                            input logic t, input logic f);
    logic ready;
    ready = (model_q.size() != DEPTH) && !f;
    if (v && ready) model_acc++;
    if (v && !ready) model_stall++;
    if (f) begin
      model_q.delete();
    end else begin
      if (t && model_q.size() != 0) void'(model_q.pop_front());
      if (v && ready) model_q.push_back(d);
    end
  endtask

  // One cycle: drive at the falling edge, check just after, update at the
  // rising edge, return at the next falling edge.
  task automatic cycle(input logic v, input logic [63:0] d,
                       input logic t, input logic f);
    s_desc_valid  = v;
    s_desc        = d;
    in_desc_taken = t;
    flush         = f;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(v, d, t, f);
    @(negedge clk);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_acc   = '0;
    model_stall = '0;
  endtask

  logic [63:0] rnd;
  logic [63:0] saved_acc;
  int          occ_before;

  initial begin
    core_reset    = 1'b1;
    s_desc        = '0;
    s_desc_valid  = 1'b0;
    in_desc_taken = 1'b0;
    flush         = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    core_reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(s_desc_ready), 64'h1);
    #1;

    // Ordered push of 1,2,3 then three pops.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
    check("occ_three", 64'(occupancy), 64'd3);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b0);
      cycle(1'b0, 64'h0, 1'b0, 1'b0);
    end
    check("empty_after_pops", 64'(in_desc_valid), 64'h0);

    // Fill to DEPTH, then hold a 17th request for 5 cycles, then one pop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);
`ifdef IN_DESC_QUEUE_STATS_EN
    check("stall_five", 64'(stall_count), 64'd5);
`endif
    // Pop while full with a push attempt: push must not happen this edge.
    cycle(1'b1, 64'hBEEF, 1'b1, 1'b0);
    check("ready_after_pop", 64'(s_desc_ready), 64'h1);
    check("occ_after_pop", 64'(occupancy), 64'(DEPTH - 1));

    // Drain to 5 entries, then push and pop together for 40 cycles.
    while (model_q.size() > 5) cycle(1'b0, 64'h0, 1'b1, 1'b0);
    occ_before = model_q.size();
    for (int i = 0; i < 40; i++) cycle(1'b1, 64'h2000 + 64'(i), 1'b1, 1'b0);
    check("occ_steady", 64'(occupancy), 64'(occ_before));

    // Flush with four stored, together with taken.
    cycle(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'h3000 + 64'(i), 1'b0, 1'b0);
    saved_acc = 64'(model_acc);
    cycle(1'b1, 64'h3333, 1'b1, 1'b1);
    check("flush_occ", 64'(occupancy), 64'h0);
    check("flush_desc", in_desc, 64'h0);
`ifdef IN_DESC_QUEUE_STATS_EN
    check("flush_acc_kept", 64'(accepted_count), saved_acc);
`endif

    // Taken on an empty queue has no effect.
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with seven stored.
    for (int i = 0; i < 7; i++) cycle(1'b1, 64'h4000 + 64'(i), 1'b0, 1'b0);
    s_desc_valid = 1'b0;
    #2;
    core_reset = 1'b1;
    #1;
    model_reset();
    check("rst_valid", 64'(in_desc_valid), 64'h0);
    check("rst_occ", 64'(occupancy), 64'h0);
    check("rst_ready", 64'(s_desc_ready), 64'h0);
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    core_reset = 1'b0;
    cycle(1'b1, 64'hAB, 1'b0, 1'b0);
    check("post_rst_desc", in_desc, 64'hAB);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom};
      cycle($urandom_range(0, 99) < 65, rnd, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 3);
    end
    cycle(1'b0, 64'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
